// File: rtl/rob_if.sv
// rob_if: groups the reorder buffer's allocate, writeback, operand-lookup
// and commit signals into one bundle.
//   master : front end / functional units / regfile side (drives alloc, wb, read ids)
//   slave  : the reorder buffer itself (drives alloc_ready/id, read results, commit)
// Parameters must match those of the rob instance the bundle is attached to.
interface rob_if #(
  parameter int ADDR_WIDTH    = 4,
  parameter int RF_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
);
  logic                     alloc_en;
  logic                     alloc_reg_wen;
  logic [RF_ADDR_WIDTH-1:0] alloc_addr;
  logic                     alloc_ready;
  logic [ADDR_WIDTH-1:0]    alloc_id;

  logic                     wb_en;
  logic [ADDR_WIDTH-1:0]    wb_id;
  logic [DATA_WIDTH-1:0]    wb_data;
  logic                     wb_exc;

  logic [ADDR_WIDTH-1:0]    read_id_1;
  logic [ADDR_WIDTH-1:0]    read_id_2;
  logic                     read_done_1;
  logic                     read_done_2;
  logic [DATA_WIDTH-1:0]    read_data_1;
  logic [DATA_WIDTH-1:0]    read_data_2;

  logic                     commit_en;
  logic                     commit_restore;
  logic [RF_ADDR_WIDTH-1:0] commit_addr;
  logic [DATA_WIDTH-1:0]    commit_data;

  modport master (
    output alloc_en, alloc_reg_wen, alloc_addr,
    input  alloc_ready, alloc_id,
    output wb_en, wb_id, wb_data, wb_exc,
    output read_id_1, read_id_2,
    input  read_done_1, read_done_2, read_data_1, read_data_2,
    input  commit_en, commit_restore, commit_addr, commit_data
  );

  modport slave (
    input  alloc_en, alloc_reg_wen, alloc_addr,
    output alloc_ready, alloc_id,
    input  wb_en, wb_id, wb_data, wb_exc,
    input  read_id_1, read_id_2,
    output read_done_1, read_done_2, read_data_1, read_data_2,
    output commit_en, commit_restore, commit_addr, commit_data
  );
endinterface

// File: rtl/rob.sv
// rob: in-order reorder buffer feeding the register file commit port.
// Entries are allocated at the tail in program order, completed out of order
// by writeback, and retired one per cycle from the head. An excepting head
// entry flushes the whole buffer and pulses commit_restore.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : rob_if.slave (alloc / wb / operand lookup / commit)
// Build option: define ROB_BYPASS_EN to let the operand read ports see a
// writeback in the same cycle it is presented; otherwise they reflect stored
// state only.
module rob #(
  parameter int ADDR_WIDTH    = 4,
  parameter int RF_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
) (
  input logic  clk,
  input logic  rst,
  rob_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] FULL_XOR = {1'b1, {ADDR_WIDTH{1'b0}}};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDR_WIDTH:0]      head, tail;
  logic [DEPTH-1:0]         valid, done, exc, reg_wen;
  logic [RF_ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0]    data_mem [DEPTH];

  logic [ADDR_WIDTH-1:0] head_idx, tail_idx;
  logic full, head_ready, flush_pend, do_commit, do_alloc, do_wb;

  assign head_idx   = head[ADDR_WIDTH-1:0];
  assign tail_idx   = tail[ADDR_WIDTH-1:0];
  assign full       = (head ^ tail) == FULL_XOR;
  assign head_ready = valid[head_idx] & done[head_idx];
  assign flush_pend = head_ready & exc[head_idx];
  assign do_commit  = head_ready & ~exc[head_idx];

  // Fullness is judged before this cycle's retirement, so a full buffer
  // cannot accept even while its head is leaving.
  assign bus.alloc_ready = !full && !flush_pend;
  assign bus.alloc_id    = tail_idx;
  assign do_alloc        = bus.alloc_en && bus.alloc_ready;
  // A freshly allocated entry is not yet valid, so a same-cycle wb to it drops.
  assign do_wb           = bus.wb_en && valid[bus.wb_id] && !flush_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head               <= '0;
      tail               <= '0;
      valid              <= '0;
      done               <= '0;
      exc                <= '0;
      reg_wen            <= '0;
      bus.commit_en      <= 1'b0;
      bus.commit_restore <= 1'b0;
      bus.commit_addr    <= '0;
      bus.commit_data    <= '0;
    end else if (flush_pend) begin
      head               <= '0;
      tail               <= '0;
      valid              <= '0;
      done               <= '0;
      bus.commit_en      <= 1'b0;
      bus.commit_restore <= 1'b1;
    end else begin
      bus.commit_en      <= 1'b0;
      bus.commit_restore <= 1'b0;
      if (do_wb) begin
        done[bus.wb_id] <= 1'b1;
        exc[bus.wb_id]  <= bus.wb_exc;
      end
      if (do_commit) begin
        bus.commit_en   <= reg_wen[head_idx];
        bus.commit_addr <= addr_mem[head_idx];
        bus.commit_data <= data_mem[head_idx];
        valid[head_idx] <= 1'b0;
        done[head_idx]  <= 1'b0;
        head            <= head + PTR_ONE;
      end
      if (do_alloc) begin
        valid[tail_idx]   <= 1'b1;
        done[tail_idx]    <= 1'b0;
        exc[tail_idx]     <= 1'b0;
        reg_wen[tail_idx] <= bus.alloc_reg_wen;
        tail              <= tail + PTR_ONE;
      end
    end
  end

  // Payload storage needs no reset; it is only observed behind valid/done.
  always_ff @(posedge clk) begin
    if (do_wb)    data_mem[bus.wb_id] <= bus.wb_data;
    if (do_alloc) addr_mem[tail_idx]  <= bus.alloc_addr;
  end

  always_comb begin
    bus.read_done_1 = valid[bus.read_id_1] & done[bus.read_id_1];
    bus.read_data_1 = bus.read_done_1 ? data_mem[bus.read_id_1] : '0;
    bus.read_done_2 = valid[bus.read_id_2] & done[bus.read_id_2];
    bus.read_data_2 = bus.read_done_2 ? data_mem[bus.read_id_2] : '0;
`ifdef ROB_BYPASS_EN
    if (bus.wb_en && bus.wb_id == bus.read_id_1 && valid[bus.read_id_1]) begin
      bus.read_done_1 = 1'b1;
      bus.read_data_1 = bus.wb_data;
    end
    if (bus.wb_en && bus.wb_id == bus.read_id_2 && valid[bus.read_id_2]) begin
      bus.read_done_2 = 1'b1;
      bus.read_data_2 = bus.wb_data;
    end
`endif
  end
endmodule
